bytestream_reg_bridge: RTL and testbench
========================================

// Module: bytestream_reg_bridge
// PURPOSE
//  Command responder on the far side of the UART bytestream: parses host commands from the UART RX byte stream,
//  performs 32-bit register reads/writes on a simple req/ack bus, and returns replies on the TX byte channel.
//  Used as a host debug/config port. Consumes produce-strobe bytes (no backpressure); drives valid/consume TX handshake.
// PARAMETERS
//  ACK_TIMEOUT   1024    cycles to wait for reg_ack before failing the access (reply 'E')
//  RX_TIMEOUT    200000  idle cycles mid-command before parser abandons command and returns to IDLE
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high
//  rx_data      in   8   received byte; valid only in the cycle rx_produce=1
//  rx_produce   in   1   one-cycle strobe: rx_data holds a new byte
//  tx_data      out  8   reply byte; stable while tx_valid=1
//  tx_valid     out  1   tx_data is valid
//  tx_consume   in   1   UART took tx_data at this posedge (only meaningful when tx_valid=1)
//  reg_addr     out  8   register address
//  reg_wdata    out  32  write data
//  reg_wr       out  1   write request, held until ack or timeout
//  reg_rd       out  1   read request, held until ack or timeout
//  reg_rdata    in   32  read data, sampled at posedge where reg_ack=1 and reg_rd=1
//  reg_ack      in   1   access complete
//  overflow     out  1   sticky: an rx byte arrived while not accepting; cleared only by reset
//  busy         out  1   1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-operation aborts immediately, including mid-reply.
//  Protocol:
//   - 'W'(0x57) addr d0 d1 d2 d3 (LSB first) -> write; reply 'K'(0x4B).
//   - 'R'(0x52) addr -> read; reply 4 bytes of rdata, LSB first.
//   - Any other byte in IDLE -> reply '?'(0x3F).
//   - Ack timeout -> reply 'E'(0x45).
//  States:
//   - IDLE: on rx_produce: 'W'/'R' -> ADDR (latch op); other -> REPLY('?', len 1).
//   - ADDR: on rx_produce latch reg_addr; op R -> EXEC; op W -> WDATA with byte index 0.
//   - WDATA: on rx_produce store byte into reg_wdata[8*idx+:8]; idx==3 -> EXEC, else idx+1.
//   - EXEC: reg_wr/reg_rd=1 from the first cycle in EXEC.
//     Posedge with reg_ack=1: drop request, capture reg_rdata (read), -> REPLY ('K' len 1 or rdata len 4).
//     Ack counter reaches ACK_TIMEOUT without ack: drop request -> REPLY('E', len 1).
//   - REPLY: tx_valid=1, tx_data=current byte. Each posedge with tx_consume=1 advances index.
//     After last byte, tx_valid=0 in the next cycle and state -> IDLE.
//  Rx acceptance:
//   - Bytes are accepted only in IDLE/ADDR/WDATA.
//   - rx_produce in EXEC/REPLY drops the byte and sets overflow=1 from the next cycle.
//  Inter-byte timeout:
//   - Counter runs in ADDR/WDATA and clears on every rx_produce.
//   - At RX_TIMEOUT: -> IDLE silently, no reply, reg_* unchanged.
//  Simultaneous events:
//   - reg_ack on the same edge as the timeout: ack wins.
//   - rx_produce on the same edge as the rx timeout: byte wins (accepted, counter cleared).
//  Read rdata is held in an internal register; reg_rdata may change after ack without affecting the reply.
//  No pipelining: one command in flight; the next command is accepted only after the final reply byte is consumed.
//  Counter widths: $clog2(param+1) bits; counters saturate, never wrap.
// TESTING
//  1. W,0x10,0x78,0x56,0x34,0x12; ack 3 cycles later -> reg_wr with addr 0x10, wdata 0x12345678; tx 0x4B; busy->0.
//  2. R,0x04; ack with rdata 0xDEADBEEF -> reg_rd one access; tx 0xEF,0xBE,0xAD,0xDE in order; tx_consume delayed 5 cycles each.
//  3. Byte 0x41 in IDLE -> tx 0x3F only; no reg_wr/reg_rd.
//  4. R,0x08, reg_ack never asserted -> reg_rd drops after ACK_TIMEOUT cycles; tx 0x45.
//  5. Send 0x52 during REPLY -> overflow=1 and stays 1; command dropped; after reset, overflow=0.
//  6. W,0x01, then idle RX_TIMEOUT cycles -> IDLE, no tx; next R,0x01 handled normally; reset mid-REPLY -> tx_valid=0 next cycle.

Source files
------------

// File: rtl/bytestream_reg_bridge_if.sv
// Byte-stream side (rx strobe, tx valid/consume) and 32-bit register req/ack bus of the host command bridge.
// The bridge takes the master modport; the UART/register-file side takes the slave modport.
interface bytestream_reg_bridge_if;
  logic [7:0]  rx_data;
  logic        rx_produce;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_consume;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wr;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  modport master (
    input  rx_data, rx_produce, tx_consume, reg_rdata, reg_ack,
    output tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd
  );

  modport slave (
    output rx_data, rx_produce, tx_consume, reg_rdata, reg_ack,
    input  tx_data, tx_valid, reg_addr, reg_wdata, reg_wr, reg_rd
  );
endinterface

// File: rtl/bytestream_reg_bridge.sv
// Host command responder: parses 'W'/'R' commands from the rx byte strobe, runs one register access
// on the req/ack bus, and streams the reply bytes out over the tx valid/consume handshake.
module bytestream_reg_bridge #(
  parameter int ACK_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 200000
) (
  input  logic clk,
  input  logic reset,
  bytestream_reg_bridge_if.master bus,
  output logic overflow,
  output logic busy
);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(RX_TIMEOUT + 1);
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [RW-1:0] RX_LAST  = RW'(RX_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, EXEC, REPLY} state_t;

  state_t        state;
  logic          op_wr;
  logic [1:0]    idx;
  logic [1:0]    last;
  logic [AW-1:0] ack_cnt;
  logic [RW-1:0] rx_cnt;
  logic [31:0]   rbuf;

  // Reply bytes are shifted out of rbuf, so the current byte is always the low byte.
  assign bus.tx_data = rbuf[7:0];
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op_wr         <= 1'b0;
      idx           <= '0;
      last          <= '0;
      ack_cnt       <= '0;
      rx_cnt        <= '0;
      rbuf          <= '0;
      overflow      <= 1'b0;
      bus.tx_valid  <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
    end else begin
      if (bus.rx_produce && (state == EXEC || state == REPLY))
        overflow <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.rx_produce) begin
            rx_cnt <= '0;
            if (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) begin
              op_wr <= (bus.rx_data == 8'h57);
              state <= ADDR;
            end else begin
              rbuf         <= 32'h0000_003F;
              last         <= 2'd0;
              idx          <= 2'd0;
              bus.tx_valid <= 1'b1;
              state        <= REPLY;
            end
          end
        end

        ADDR, WDATA: begin
          // A byte arriving on the timeout edge still counts; the counter restarts.
          if (bus.rx_produce) begin
            rx_cnt <= '0;
            if (state == ADDR) begin
              bus.reg_addr <= bus.rx_data;
              idx          <= 2'd0;
              if (op_wr) begin
                state <= WDATA;
              end else begin
                bus.reg_rd <= 1'b1;
                ack_cnt    <= '0;
                state      <= EXEC;
              end
            end else begin
              bus.reg_wdata[8*idx +: 8] <= bus.rx_data;
              if (idx == 2'd3) begin
                bus.reg_wr <= 1'b1;
                ack_cnt    <= '0;
                state      <= EXEC;
              end else begin
                idx <= idx + 2'd1;
              end
            end
          end else if (rx_cnt == RX_LAST) begin
            state <= IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end

        EXEC: begin
          // Ack is checked first so an ack on the timeout edge completes the access.
          if (bus.reg_ack) begin
            bus.reg_wr   <= 1'b0;
            bus.reg_rd   <= 1'b0;
            idx          <= 2'd0;
            bus.tx_valid <= 1'b1;
            state        <= REPLY;
            if (op_wr) begin
              rbuf <= 32'h0000_004B;
              last <= 2'd0;
            end else begin
              rbuf <= bus.reg_rdata;
              last <= 2'd3;
            end
          end else if (ack_cnt == ACK_LAST) begin
            bus.reg_wr   <= 1'b0;
            bus.reg_rd   <= 1'b0;
            rbuf         <= 32'h0000_0045;
            last         <= 2'd0;
            idx          <= 2'd0;
            bus.tx_valid <= 1'b1;
            state        <= REPLY;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end

        REPLY: begin
          if (bus.tx_consume) begin
            if (idx == last) begin
              bus.tx_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              idx  <= idx + 2'd1;
              rbuf <= {8'h00, rbuf[31:8]};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bytestream_reg_bridge.sv
// Self-checking bench: table of command vectors plus hand sequences for timeouts, overflow and reset.
module tb_bytestream_reg_bridge;
  localparam int ACK_T = 32;
  localparam int RX_T  = 60;

  logic clk = 1'b0;
  logic reset;
  logic overflow, busy;

  always #5 clk = ~clk;

  bytestream_reg_bridge_if bus();

  bytestream_reg_bridge #(.ACK_TIMEOUT(ACK_T), .RX_TIMEOUT(RX_T)) dut (
    .clk(clk), .reset(reset), .bus(bus), .overflow(overflow), .busy(busy)
  );

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct {
    int          n;      // rx bytes, first byte in bits [7:0]
    logic [47:0] rx;
    int          ntx;    // expected tx bytes, first byte in bits [7:0]
    logic [31:0] tx;
    bit          acc;
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cdly;
    int          adly;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_tx[$];
  acc_t       exp_acc[$];
  int consume_delay = 0, ack_delay = 0, cwait = 0, await_n = 0, req_cycles = 0;
  bit ack_en = 1'b1;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: score handshakes that complete at the coming edge, then update the UART and register models.
  task automatic step();
    bit fire_tx, fire_ack;
    logic [7:0] txb;
    acc_t a;
    fire_tx  = bus.tx_valid && bus.tx_consume;
    txb      = bus.tx_data;
    fire_ack = bus.reg_ack && (bus.reg_wr || bus.reg_rd);
    if (bus.reg_wr || bus.reg_rd) req_cycles++;
    if (fire_tx) begin
      if (exp_tx.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_extra: got %h want none", txb);
      end else begin
        chk("tx_byte", {24'h0, txb}, {24'h0, exp_tx.pop_front()});
      end
    end
    if (fire_ack) begin
      if (exp_acc.size() == 0) begin
        total++; bad++;
        $display("FAIL acc_extra: got wr=%b addr=%h want none", bus.reg_wr, bus.reg_addr);
      end else begin
        a = exp_acc.pop_front();
        chk("acc_wr", {31'h0, bus.reg_wr}, {31'h0, a.wr});
        chk("acc_rd", {31'h0, bus.reg_rd}, {31'h0, ~a.wr});
        chk("acc_addr", {24'h0, bus.reg_addr}, {24'h0, a.addr});
        if (a.wr) chk("acc_wdata", bus.reg_wdata, a.wdata);
      end
    end
    @(posedge clk);
    #1;
    bus.rx_produce = 1'b0;
    if (fire_tx || !bus.tx_valid) begin
      bus.tx_consume = 1'b0;
      cwait = 0;
    end else if (cwait >= consume_delay) begin
      bus.tx_consume = 1'b1;
    end else begin
      cwait++;
    end
    if (fire_ack) begin
      bus.reg_ack   = 1'b0;
      await_n       = 0;
      bus.reg_rdata = 32'h0BAD_F00D;
    end else if ((bus.reg_wr || bus.reg_rd) && ack_en) begin
      if (await_n >= ack_delay) bus.reg_ack = 1'b1;
      else await_n++;
    end else begin
      bus.reg_ack = 1'b0;
      await_n     = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data    = b;
    bus.rx_produce = 1'b1;
    step();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || bus.tx_valid) && n < 2000) begin
      step();
      n++;
    end
    chk({name, "_idle"}, {31'h0, busy}, 32'h0);
    chk({name, "_tx_left"}, exp_tx.size(), 32'h0);
    chk({name, "_acc_left"}, exp_acc.size(), 32'h0);
  endtask

  task automatic push_acc(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
    acc_t a;
    a.wr = wr; a.addr = addr; a.wdata = wdata;
    exp_acc.push_back(a);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{6, 48'h12_34_56_78_10_57, 1, 32'h4B, 1, 1, 8'h10, 32'h1234_5678, 32'h0, 0, 3};
    vt[1] = '{2, 48'h04_52, 4, 32'hDEAD_BEEF, 1, 0, 8'h04, 32'h0, 32'hDEAD_BEEF, 5, 0};
    vt[2] = '{1, 48'h41, 1, 32'h3F, 0, 0, 8'h00, 32'h0, 32'h0, 0, 0};
    vt[3] = '{6, 48'h80_00_00_00_FF_57, 1, 32'h4B, 1, 1, 8'hFF, 32'h8000_0000, 32'h0, 0, 0};
    vt[4] = '{2, 48'h7E_52, 4, 32'h0102_0304, 1, 0, 8'h7E, 32'h0, 32'h0102_0304, 1, ACK_T - 1};
    vt[5] = '{1, 48'h00, 1, 32'h3F, 0, 0, 8'h00, 32'h0, 32'h0, 2, 0};
    vt[6] = '{6, 48'h3C_C3_5A_A5_55_57, 1, 32'h4B, 1, 1, 8'h55, 32'h3CC3_5AA5, 32'h0, 2, 10};

    reset = 1'b1;
    bus.rx_data = 8'h00; bus.rx_produce = 1'b0; bus.tx_consume = 1'b0;
    bus.reg_rdata = 32'h0; bus.reg_ack = 1'b0;
    step(); step();
    chk("rst_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'h0, bus.tx_data}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_reg_wr", {31'h0, bus.reg_wr}, 32'h0);
    chk("rst_reg_rd", {31'h0, bus.reg_rd}, 32'h0);
    chk("rst_reg_addr", {24'h0, bus.reg_addr}, 32'h0);
    chk("rst_reg_wdata", bus.reg_wdata, 32'h0);
    reset = 1'b0;

    foreach (vt[i]) begin
      consume_delay = vt[i].cdly;
      ack_delay     = vt[i].adly;
      ack_en        = 1'b1;
      bus.reg_rdata = vt[i].rdata;
      for (int k = 0; k < vt[i].ntx; k++) exp_tx.push_back(vt[i].tx[8*k +: 8]);
      if (vt[i].acc) push_acc(vt[i].wr, vt[i].addr, vt[i].wdata);
      for (int k = 0; k < vt[i].n; k++) begin
        send(vt[i].rx[8*k +: 8]);
        step();
      end
      wait_idle("vec");
    end

    // Read with no ack: request held exactly ACK_T cycles, then 'E'.
    ack_en = 1'b0; consume_delay = 0; req_cycles = 0;
    exp_tx.push_back(8'h45);
    send(8'h52); step(); send(8'h08);
    wait_idle("ack_to");
    chk("ack_to_req_cycles", req_cycles, ACK_T);
    ack_en = 1'b1;

    // Byte during REPLY is dropped and overflow sticks until reset.
    consume_delay = 10;
    exp_tx.push_back(8'h3F);
    send(8'h41); step(); step();
    chk("ovf_in_reply", {31'h0, bus.tx_valid}, 32'h1);
    send(8'h52);
    chk("ovf_set", {31'h0, overflow}, 32'h1);
    wait_idle("ovf");
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
    reset = 1'b1; step(); step(); reset = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);

    // Partial write abandoned by the inter-byte timeout, then a normal read.
    consume_delay = 0;
    send(8'h57); step(); send(8'h01);
    repeat (RX_T - 5) step();
    chk("rxto_still_busy", {31'h0, busy}, 32'h1);
    repeat (10) step();
    chk("rxto_idle", {31'h0, busy}, 32'h0);
    chk("rxto_no_tx", {31'h0, bus.tx_valid}, 32'h0);
    bus.reg_rdata = 32'hCAFE_0001;
    exp_tx.push_back(8'h01); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'hFE); exp_tx.push_back(8'hCA);
    push_acc(1'b0, 8'h01, 32'h0);
    send(8'h52); send(8'h01);
    wait_idle("after_rxto");

    // Reset in the middle of a reply kills tx_valid on the next edge.
    consume_delay = 20;
    bus.reg_rdata = 32'h1122_3344;
    push_acc(1'b0, 8'h02, 32'h0);
    send(8'h52); send(8'h02);
    for (int n = 0; n < 100 && !bus.tx_valid; n++) step();
    chk("mid_reply_valid", {31'h0, bus.tx_valid}, 32'h1);
    chk("mid_reply_acc_done", exp_acc.size(), 32'h0);
    reset = 1'b1; step();
    chk("mid_reply_rst_valid", {31'h0, bus.tx_valid}, 32'h0);
    chk("mid_reply_rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    exp_tx.delete();
    consume_delay = 0;
    exp_tx.push_back(8'h3F);
    send(8'h41);
    wait_idle("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
